decoding: RTL and testbench

//  Huffman (prefix-code) decoder for one 8x8 block of signed 8-bit coefficients.

---
 rtl/decoding_if.sv | 11 +
 rtl/decoding.sv | 149 ++++++++++++++
 tb/tb_decoding.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/decoding_if.sv
// Bus bundle for the block Huffman decoder: start/hold, packed bitstream in,
// packed coefficient block and completion flag out.
interface decoding_if;
  logic         Enable;
  logic [511:0] A;
  logic [511:0] C;
  logic         done;

  modport master (output Enable, output A, input C, input done);
  modport slave (input Enable, input A, output C, output done);
endinterface

// File: rtl/decoding.sv
// Bit-serial prefix-code decoder: expands one 512-bit coded block into 64 signed
// 8-bit coefficients (row-major, coeff k at C[k*8+:8]), one code bit per clock.
module decoding (
  input logic       Clock,
  input logic       reset,
  decoding_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLoad, StDecode, StDone} state_e;

  state_e       state_q, state_d;
  logic [511:0] sr_q, sr_d;
  logic [511:0] c_q, c_d;
  logic [8:0]   ptr_q, ptr_d;
  logic [5:0]   k_q, k_d;
  logic [1:0]   ones_q, ones_d;
  logic         lit_q, lit_d;
  logic [2:0]   lit_cnt_q, lit_cnt_d;
  logic [6:0]   lit_val_q, lit_val_d;
  logic         done_q, done_d;

  logic         code_bit;
  logic         write;
  logic [7:0]   wval;
  logic         eob;

  assign bus.C    = c_q;
  assign bus.done = done_q;
  assign code_bit = sr_q[0];

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    c_d       = c_q;
    ptr_d     = ptr_q;
    k_d       = k_q;
    ones_d    = ones_q;
    lit_d     = lit_q;
    lit_cnt_d = lit_cnt_q;
    lit_val_d = lit_val_q;
    done_d    = done_q;
    write     = 1'b0;
    wval      = 8'h00;
    eob       = 1'b0;

    unique case (state_q)
      StIdle: begin
        done_d = 1'b0;
        if (bus.Enable) state_d = StLoad;
      end

      StLoad: begin
        if (!bus.Enable) begin
          state_d = StIdle;
        end else begin
          sr_d      = bus.A;
          c_d       = '0;
          ptr_d     = '0;
          k_d       = '0;
          ones_d    = '0;
          lit_d     = 1'b0;
          lit_cnt_d = '0;
          lit_val_d = '0;
          state_d   = StDecode;
        end
      end

      StDecode: begin
        if (!bus.Enable) begin
          state_d = StIdle;
        end else begin
          sr_d  = sr_q >> 1;
          ptr_d = ptr_q + 9'd1;
          if (lit_q) begin
            // Payload arrives LSB first; the eighth bit completes the literal.
            lit_val_d = {code_bit, lit_val_q[6:1]};
            lit_cnt_d = lit_cnt_q + 3'd1;
            if (lit_cnt_q == 3'd7) begin
              write = 1'b1;
              wval  = {code_bit, lit_val_q};
              lit_d = 1'b0;
            end
          end else if (code_bit) begin
            if (ones_q == 2'd3) eob = 1'b1;
            else ones_d = ones_q + 2'd1;
          end else begin
            ones_d = '0;
            unique case (ones_q)
              2'd0: begin write = 1'b1; wval = 8'h00; end
              2'd1: begin write = 1'b1; wval = 8'h01; end
              2'd2: begin write = 1'b1; wval = 8'hff; end
              default: begin
                lit_d     = 1'b1;
                lit_cnt_d = '0;
              end
            endcase
          end

          if (write) begin
            c_d[{k_q, 3'b000} +: 8] = wval;
            k_d = k_q + 6'd1;
          end

          // A code cut off by the 512-bit limit is simply dropped.
          if (eob || (write && k_q == 6'd63) || ptr_q == 9'd511) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end

      StDone: begin
        if (!bus.Enable) begin
          state_d = StIdle;
          done_d  = 1'b0;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      c_q       <= '0;
      ptr_q     <= '0;
      k_q       <= '0;
      ones_q    <= '0;
      lit_q     <= 1'b0;
      lit_cnt_q <= '0;
      lit_val_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      c_q       <= c_d;
      ptr_q     <= ptr_d;
      k_q       <= k_d;
      ones_q    <= ones_d;
      lit_q     <= lit_d;
      lit_cnt_q <= lit_cnt_d;
      lit_val_q <= lit_val_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_decoding.sv
// Table-driven bench for the block decoder: vectors are built up front, expected
// blocks and latencies go through a scoreboard queue and are checked when done rises.
module tb_decoding;

  typedef struct {
    logic [511:0] a;
    logic [511:0] c;
    int           n;
  } vec_t;

  logic Clock = 1'b0;
  logic reset = 1'b0;
  decoding_if bus ();

  decoding dut (
    .Clock (Clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];
  vec_t sb[$];
  logic signed [7:0] vals[64];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference encoder: packs vals[0..n-1] (plus optional EOB) into a stream,
  // truncating at 512 bits, and records the block and bit count the decoder should yield.
  function automatic vec_t encode(input int n, input bit add_eob);
    vec_t v;
    int p;
    int len;
    bit trunc;
    logic [11:0] code;
    v.a = '0; v.c = '0; p = 0; trunc = 1'b0;
    for (int i = 0; i < n && !trunc; i++) begin
      if (vals[i] == 8'sd0) begin code = 12'h000; len = 1; end
      else if (vals[i] == 8'sd1) begin code = 12'h001; len = 2; end
      else if (vals[i] == -8'sd1) begin code = 12'h003; len = 3; end
      else begin code = {vals[i], 4'b0111}; len = 12; end
      if (p + len > 512) trunc = 1'b1;
      else v.c[i*8 +: 8] = vals[i];
      for (int b = 0; b < len; b++) begin
        if (p < 512) v.a[p] = code[b];
        p++;
      end
    end
    if (!trunc && add_eob) begin
      for (int b = 0; b < 4; b++) begin
        if (p < 512) v.a[p] = 1'b1;
        p++;
      end
    end
    if (!trunc && !add_eob && n < 64) p += 64 - n;
    v.n = (p > 512) ? 512 : p;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    vec_t exp;
    int edges;
    bit got;
    @(negedge Clock);
    bus.A = v.a;
    bus.Enable = 1'b1;
    sb.push_back(v);
    edges = 0;
    got = 1'b0;
    while (!got && edges < v.n + 10) begin
      @(posedge Clock);
      edges++;
      #1;
      if (bus.done) got = 1'b1;
      // Scramble A after LOAD: it must no longer matter.
      if (edges == 2) bus.A = {16{$urandom}};
    end
    exp = sb.pop_front();
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: done never rose within %0d edges", tag, edges);
    end else begin
      check({tag, " done edge"}, 512'(edges), 512'(exp.n + 2));
      check({tag, " C"}, bus.C, exp.c);
      @(posedge Clock);
      #1;
      check({tag, " done hold"}, 512'(bus.done), 512'(1));
      check({tag, " C hold"}, bus.C, exp.c);
    end
    @(negedge Clock);
    bus.Enable = 1'b0;
    @(posedge Clock);
    #1;
    check({tag, " done drop"}, 512'(bus.done), 512'(0));
  endtask

  initial begin
    vec_t v;
    bus.Enable = 1'b0;
    bus.A = '0;

    // Spec scenarios 1-5 as raw bit patterns.
    v.a = '0; v.c = '0; v.n = 64; vecs.push_back(v);
    v.a = '0; v.a[3:0] = 4'b1111; v.c = '0; v.n = 4; vecs.push_back(v);
    v.a = '0; v.a[1:0] = 2'b01; v.c = '0; v.c[7:0] = 8'h01; v.n = 65; vecs.push_back(v);
    v.a = '0; v.a[3:0] = 4'b0111; v.a[11:4] = 8'h81; v.a[15:12] = 4'b1111;
    v.c = '0; v.c[7:0] = 8'h81; v.n = 16; vecs.push_back(v);
    v.a = '0; v.a[2:0] = 3'b011; v.a[7:4] = 4'b1111;
    v.c = '0; v.c[7:0] = 8'hff; v.n = 8; vecs.push_back(v);
    // Literal-coded 0 and +1.
    v.a = '0; v.a[3:0] = 4'b0111; v.a[15:12] = 4'b0111; v.a[23:16] = 8'h01;
    v.a[27:24] = 4'b1111; v.c = '0; v.c[15:8] = 8'h01; v.n = 28; vecs.push_back(v);

    // Mixed random codes ending in EOB.
    for (int i = 0; i < 64; i++) begin
      case ($urandom_range(0, 3))
        0: vals[i] = 8'sd0;
        1: vals[i] = 8'sd1;
        2: vals[i] = -8'sd1;
        default: vals[i] = 8'($urandom_range(2, 127));
      endcase
    end
    vecs.push_back(encode(20, 1'b1));
    // 64 short codes: stops on coefficient count with stream bits to spare.
    for (int i = 0; i < 64; i++) vals[i] = 8'($urandom_range(0, 2)) - 8'sd1;
    vecs.push_back(encode(64, 1'b0));
    // All literals: the 512-bit limit cuts the 43rd code.
    for (int i = 0; i < 64; i++) vals[i] = (i % 2 == 0) ? -8'sd128 : 8'sd127 - 8'(i);
    vecs.push_back(encode(64, 1'b0));

    #12;
    check("reset C", bus.C, '0);
    check("reset done", 512'(bus.done), 512'(0));
    @(negedge Clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-decode, then restart the same block.
    @(negedge Clock);
    bus.A = vecs[2].a;
    bus.Enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge Clock);
      #1;
      check("abort pre done", 512'(bus.done), 512'(0));
    end
    @(negedge Clock);
    bus.Enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock);
      #1;
      check("abort done low", 512'(bus.done), 512'(0));
    end
    run_vec(vecs[2], "restart");

    // Reset mid-decode once coefficient 0 already holds +1.
    @(negedge Clock);
    bus.A = vecs[2].a;
    bus.Enable = 1'b1;
    repeat (8) @(posedge Clock);
    @(negedge Clock);
    check("pre-reset C", bus.C, vecs[2].c);
    reset = 1'b0;
    #1;
    check("mid reset C", bus.C, '0);
    check("mid reset done", 512'(bus.done), 512'(0));
    bus.Enable = 1'b0;
    @(negedge Clock);
    reset = 1'b1;
    run_vec(vecs[3], "post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
